// File: rtl/mem_if_pkg.sv
// Shared types and default parameters for the Data_Mem access controller.
package mem_if_pkg;

    localparam int          DATA_W_DEF      = 16;
    localparam int          ADDR_W_DEF      = 16;
    localparam int          MEM_DEPTH_DEF   = 256;
    localparam logic [15:0] READ_WD_TAG_DEF = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// 4-bit wait-state down-counter: load, decrement (saturating at 0) and zero flag.
module mem_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: a load has priority over a decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Count register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the single-port Data_Mem.
// Optional bounds check enabled by defining MEM_ACCESS_BOUNDS_CHECK_EN.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request handshake
// ACCESS | driving Data_Mem for WAIT_CYCLES+1 cycles; write strobe in the last one
// RESP   | response held on rsp_* until rsp_ready
//
// All outputs are registered. The mem_* pins reflect the state of the previous
// cycle, so a read is sampled at the end of the last cycle in which mem_re is
// high, and rsp_valid rises one cycle after the FSM enters RESP.
module mem_access_ctrl
    import mem_if_pkg::*;
#(
    parameter int               DATA_W      = DATA_W_DEF,
    parameter int               ADDR_W      = ADDR_W_DEF,
    parameter int               MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int               WAIT_CYCLES = 0,
    parameter logic [DATA_W-1:0] READ_WD_TAG = DATA_W'(READ_WD_TAG_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rd
);

    mem_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic              last_q, last_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;
    logic accept;
    logic addr_oob;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    assign addr_oob = (32'(req_addr) >= 32'(MEM_DEPTH));
`else
    // Every address is forwarded; the depth only matters for the bounds check.
    logic unused_depth;
    assign unused_depth = ^(32'(MEM_DEPTH));
    assign addr_oob     = 1'b0;
`endif

    mem_wait_timer u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (4'(WAIT_CYCLES)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q;

    // Next state, request latch, timer control and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_a_d     = '0;
        mem_wd_d    = '0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        last_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    tmr_load    = 1'b1;
                    rsp_rdata_d = '0;
                    if (addr_oob) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        rsp_err_d = 1'b0;
                        state_d   = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                mem_a_d = addr_q;
                if (we_q) begin
                    mem_wd_d = wdata_q;
                    mem_we_d = tmr_zero;
                end else begin
                    mem_wd_d = READ_WD_TAG;
                    mem_re_d = 1'b1;
                end
                last_d = tmr_zero;
                if (tmr_zero) begin
                    state_d = ST_RESP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The final read cycle is on the pins now; capture what Data_Mem returns.
        if (last_q && mem_re_q) begin
            rsp_rdata_d = mem_rd;
        end

        req_ready_d = (state_d == ST_IDLE);
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_a_q     <= '0;
            mem_wd_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_a_q     <= mem_a_d;
            mem_wd_q    <= mem_wd_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            last_q      <= last_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_a     = mem_a_q;
    assign mem_wd    = mem_wd_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

endmodule
